// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the EX stage.
// Owns HI/LO, sequences multi-cycle MULT/MULTU/DIV/DIVU and exposes a busy window.
// The result is computed when the operation is accepted and held in shadow registers.
// The shadow commits to HI/LO atomically when the countdown expires.
// Optional feature macro: MD_MADD_EN enables md_op=7 (signed multiply-accumulate).
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        kill,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [31:0]    sh_hi_reg, sh_hi_next;
    logic [31:0]    sh_lo_reg, sh_lo_next;
    logic [31:0]    hi_reg, hi_next;
    logic [31:0]    lo_reg, lo_next;

    logic           effective;
    logic           is_md;
    logic [31:0]    res_hi, res_lo;
    logic [CW-1:0]  load_cnt;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] a_s, dv_s, sq, sr;
    logic [31:0]        dv_u, uq, ur;
    logic               div_zero, div_ovf;

    assign busy = (state_reg == BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Datapath: products and quotients computed in parallel from the forwarded operands
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        // 0x80000000 / -1 overflows; dividing by 1 instead yields the required q=A, r=0
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        a_s      = $signed(A);
        dv_s     = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
        dv_u     = div_zero ? 32'd1 : B;
        sq       = a_s / dv_s;
        sr       = a_s % dv_s;
        uq       = A / dv_u;
        ur       = A % dv_u;
    end

    // Operation decode and selection of the value the shadow registers will hold
    always_comb begin
        effective = (md_op != 3'd0) && !kill;
        is_md     = 1'b0;
        res_hi    = hi_reg;
        res_lo    = lo_reg;
        load_cnt  = MULT_LOAD;
        case (md_op)
            OP_MULT: begin
                is_md  = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                is_md  = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                is_md    = 1'b1;
                load_cnt = DIV_LOAD;
                if (!div_zero) begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OP_DIVU: begin
                is_md    = 1'b1;
                load_cnt = DIV_LOAD;
                if (!div_zero) begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
                is_md            = 1'b1;
                {res_hi, res_lo} = {hi_reg, lo_reg} + prod_s;
            end
`endif
            default: ;
        endcase
        start = effective && is_md && (state_reg == IDLE);
    end

    // Next-state logic: accept in IDLE, count down in BUSY, commit on expiry
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sh_hi_next = sh_hi_reg;
        sh_lo_next = sh_lo_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = load_cnt;
                    sh_hi_next = res_hi;
                    sh_lo_next = res_lo;
                end else if (effective && md_op == OP_MTHI) begin
                    hi_next = A;
                end else if (effective && md_op == OP_MTLO) begin
                    lo_next = A;
                end
            end
            BUSY: begin
                // Any op arriving here is a stall violation and is deliberately ignored
                if (cnt_reg == '0) begin
                    hi_next    = sh_hi_reg;
                    lo_next    = sh_lo_reg;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, shadow and HI/LO registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sh_hi_reg <= '0;
            sh_lo_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sh_hi_reg <= sh_hi_next;
            sh_lo_reg <= sh_lo_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // OP_MADD is referenced only when the accumulate feature is built in
    logic unused_ok;
    assign unused_ok = ^OP_MADD;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: table-driven vectors plus hand-written corner sequences for md_sched.
// Expected HI/LO pairs are queued when an op is driven and popped once busy drops.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic        kill;
    logic [31:0] A, B;
    logic        busy, start;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] sb_q[$];

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .kill  (kill),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .start (start),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        k;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_start;
        int          exp_cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one op for a cycle, then measure the busy window and compare HI/LO
    task automatic run_op(input int idx, input vec_t v);
        int cyc;
        logic [63:0] e;
        @(negedge clk);
        md_op = v.op; kill = v.k; A = v.a; B = v.b;
        sb_q.push_back({v.exp_hi, v.exp_lo});
        #1;
        chk("start", {31'd0, start}, {31'd0, v.exp_start});
        @(posedge clk);
        #1;
        md_op = 3'd0; kill = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", cyc, v.exp_cycles);
        e = sb_q.pop_front();
        chk("hi", hi, e[63:32]);
        chk("lo", lo, e[31:0]);
        $display("vec %0d op=%0d kill=%0d A=%h B=%h -> busy %0d cycles hi=%h lo=%h",
                 idx, v.op, v.k, v.a, v.b, cyc, hi, lo);
    endtask

    initial begin
        int cyc;
        md_op = 3'd0; kill = 1'b0; A = '0; B = '0;
        reset = 1'b1;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        //           op    k     A              B              st  cyc  hi             lo
        vecs[0]  = '{3'd1, 1'b0, 32'hFFFFFFFE, 32'd3,         1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd4, 1'b0, 32'd100,      32'd7,         1'b1, 10, 32'd2,        32'd14};
        vecs[2]  = '{3'd3, 1'b0, 32'hFFFFFFF9, 32'd2,         1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd5, 1'b0, 32'h1234,     32'd0,         1'b0, 0,  32'h1234,     32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 1'b0, 32'd5,        32'd0,         1'b1, 10, 32'h1234,     32'hFFFFFFFD};
        vecs[5]  = '{3'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF,  1'b1, 10, 32'd0,        32'h80000000};
        vecs[6]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,  1'b1, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{3'd1, 1'b1, 32'd2,        32'd3,         1'b0, 0,  32'hFFFFFFFE, 32'h00000001};
        vecs[8]  = '{3'd6, 1'b0, 32'hFFFFFFFF, 32'd0,         1'b0, 0,  32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[9]  = '{3'd5, 1'b0, 32'd0,        32'd0,         1'b0, 0,  32'd0,        32'hFFFFFFFF};
`ifdef MD_MADD_EN
        vecs[10] = '{3'd7, 1'b0, 32'd1,        32'd1,         1'b1, 5,  32'd1,        32'd0};
`else
        vecs[10] = '{3'd7, 1'b0, 32'd1,        32'd1,         1'b0, 0,  32'd0,        32'hFFFFFFFF};
`endif
        vecs[11] = '{3'd1, 1'b0, 32'h7FFFFFFF, 32'h80000000,  1'b1, 5,  32'hC0000000, 32'h80000000};
        vecs[12] = '{3'd4, 1'b0, 32'hFFFFFFFF, 32'h10,        1'b1, 10, 32'hF,        32'h0FFFFFFF};
        vecs[13] = '{3'd3, 1'b0, 32'd7,        32'hFFFFFFFE,  1'b1, 10, 32'd1,        32'hFFFFFFFD};
        vecs[14] = '{3'd4, 1'b0, 32'd9,        32'd0,         1'b1, 10, 32'd1,        32'hFFFFFFFD};

        for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

        // MULTU in flight; an MTLO at busy cycle 2 must be ignored
        @(negedge clk);
        md_op = 3'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
        @(posedge clk); #1;
        md_op = 3'd0;
        @(posedge clk); #1;
        md_op = 3'd6; A = 32'hAA;
        #1;
        chk("mt_busy_start", {31'd0, start}, 32'd0);
        @(posedge clk); #1;
        md_op = 3'd0;
        chk("mt_busy_lo", lo, 32'hFFFFFFFD);
        cyc = 2;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("mt_busy_cycles", cyc, 5);
        begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("mt_busy_hi_final", hi, e[63:32]);
            chk("mt_busy_lo_final", lo, e[31:0]);
        end
        $display("seq mtlo-during-multu -> busy %0d cycles hi=%h lo=%h", cyc, hi, lo);

        // DIV interrupted by reset during busy cycle 3: no later commit
        @(negedge clk);
        md_op = 3'd4; A = 32'd50; B = 32'd5;
        @(posedge clk); #1;
        md_op = 3'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || lo !== 32'd0) break;
        end
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);
        $display("seq reset-mid-div -> busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
